st2mm_vdm_rx_buf: RTL

Receives the MCTP-over-PCIe VDM stream steered to the UMSG port of the ST2MM packet filter and reassembles each message into a single-packet buffer. It validates the header length field against the beats actually received and drops bad or oversized messages. A good message is held, with its header, for the management controller to read DW by DW; the host releases it with a done pulse, and the stream is back-pressured while a message is held.

---
 rtl/st2mm_vdm_rx_buf_if.sv | 16 +
 rtl/st2mm_vdm_rx_buf.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/st2mm_vdm_rx_buf_if.sv
// AXI-Stream bundle used for the PCIe subsystem VDM streams.
// The sink modport is the receiving side: it drives only tready.
interface pcie_ss_axis_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10
) ();
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser_vendor;

  modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
  modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
endinterface

// File: rtl/st2mm_vdm_rx_buf.sv
// MCTP-over-PCIe VDM receive buffer.
// Reassembles one message from the UMSG stream, checks the header length
// field against the number of beats actually received, drops bad or
// oversized messages, and holds a good message (header + payload) for
// DW-by-DW readout until the host releases it with pkt_done.
module st2mm_vdm_rx_buf #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10,
  parameter int MAX_PLD_DW  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pcie_ss_axis_if.sink                  rx_st_if,
  output logic                          pkt_valid,
  output logic [127:0]                  pkt_hdr,
  output logic [10:0]                   pkt_len_dw,
  input  logic [$clog2(MAX_PLD_DW)-1:0] rd_addr,
  output logic [31:0]                   rd_data,
  input  logic                          pkt_done,
  output logic [15:0]                   rx_cnt,
  output logic [15:0]                   drop_cnt
);

  localparam int          AW      = $clog2(MAX_PLD_DW);
  localparam logic [10:0] MAX_LEN = 11'(MAX_PLD_DW);

  typedef enum logic [1:0] {IDLE, RECV, DROP, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ready;
  logic        beat_acc;
  logic        drop_evt;
  logic        hold_entry;
  logic [10:0] sop_len;
  logic [10:0] sop_exp;
  logic [10:0] exp_beats;
  logic [10:0] beat_cnt;
  logic [15:0] wr_base;
  logic [31:0] pld_mem [MAX_PLD_DW];
  logic        unused_bits;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Beats needed for a payload of len DW: 8 DW ride with the header,
  // 16 DW on every following beat.
  function automatic logic [10:0] exp_beats_f(input logic [10:0] len);
    if (len <= 11'd8) return 11'd1;
    return 11'd1 + ((len + 11'd7) >> 4);
  endfunction

  // A length field of zero encodes 1024 DW.
  assign sop_len     = (rx_st_if.tdata[9:0] == 10'd0) ? 11'd1024
                                                      : {1'b0, rx_st_if.tdata[9:0]};
  assign sop_exp     = exp_beats_f(sop_len);
  assign beat_acc    = rx_st_if.tvalid & ready;
  assign hold_entry  = (state != HOLD) && (state_nxt == HOLD);
  assign wr_base     = 16'd8 + 16'({beat_cnt - 11'd1, 4'b0000});
  assign rx_st_if.tready = ready;
  // tkeep and tuser_vendor are carried on the bus but the length field alone
  // decides which DW are meaningful.
  assign unused_bits = ^{rx_st_if.tkeep, rx_st_if.tuser_vendor};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and drop detection
  always_comb begin
    state_nxt = state;
    drop_evt  = 1'b0;
    case (state)
      IDLE: if (beat_acc) begin
        if (sop_len > MAX_LEN) begin
          if (rx_st_if.tlast) drop_evt  = 1'b1;
          else                state_nxt = DROP;
        end else if (sop_exp == 11'd1) begin
          // A single-beat message that keeps going is overlong.
          state_nxt = rx_st_if.tlast ? HOLD : DROP;
        end else if (rx_st_if.tlast) begin
          drop_evt = 1'b1;
        end else begin
          state_nxt = RECV;
        end
      end
      RECV: if (beat_acc) begin
        if (beat_cnt == exp_beats - 11'd1) begin
          state_nxt = rx_st_if.tlast ? HOLD : DROP;
        end else if (rx_st_if.tlast) begin
          drop_evt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: if (beat_acc && rx_st_if.tlast) begin
        drop_evt  = 1'b1;
        state_nxt = IDLE;
      end
      HOLD: if (pkt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    ready     = (state != HOLD);
    pkt_valid = (state == HOLD);
  end

  // Header/length capture, beat counting, readout register and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_hdr    <= '0;
      pkt_len_dw <= '0;
      exp_beats  <= '0;
      beat_cnt   <= '0;
      rd_data    <= '0;
      rx_cnt     <= '0;
      drop_cnt   <= '0;
    end else begin
      if (state == IDLE && beat_acc) begin
        pkt_hdr    <= rx_st_if.tdata[127:0];
        pkt_len_dw <= sop_len;
        exp_beats  <= sop_exp;
        beat_cnt   <= 11'd1;
      end else if (state == RECV && beat_acc) begin
        beat_cnt <= beat_cnt + 11'd1;
      end
      if (state == HOLD && 11'(rd_addr) < pkt_len_dw) rd_data <= pld_mem[rd_addr];
      else                                             rd_data <= '0;
      if (hold_entry) rx_cnt   <= sat_inc(rx_cnt);
      if (drop_evt)   drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Payload buffer writes; contents are not reset
  always_ff @(posedge clk) begin
    if (state == IDLE && beat_acc) begin
      for (int j = 0; j < 8; j++)
        pld_mem[AW'(j)] <= rx_st_if.tdata[256 + 32*j +: 32];
    end else if (state == RECV && beat_acc) begin
      for (int j = 0; j < 16; j++)
        if (int'(wr_base) + j < MAX_PLD_DW)
          pld_mem[AW'(int'(wr_base) + j)] <= rx_st_if.tdata[32*j +: 32];
    end
  end

endmodule
